// File: rtl/flash_burst_arbiter.sv
// flash_burst_arbiter: round-robin arbiter turning two burst read requests into byte reads on a flash port
//   clk_i, rst_i             : clock, synchronous active-high reset
//   reqN_valid_i/addr_i/len_i : burst request (len = byte count - 1), held until reqN_ready_o
//   reqN_ready_o             : accept pulse
//   reqN_rvalid_o/rdata_o    : returned byte strobe and data
//   reqN_done_o              : pulse alongside the last byte of a burst
//   mem_valid_o/addr_o       : byte read request to the flash interface
//   mem_ready_i/rdata_i      : byte completion pulse and data
//   busy_o, grant_o          : burst in progress, owner of the current burst
module flash_burst_arbiter #(
    parameter int LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    input  logic [23:0]      req0_addr_i,
    input  logic [LEN_W-1:0] req0_len_i,
    output logic             req0_ready_o,
    output logic             req0_rvalid_o,
    output logic [7:0]       req0_rdata_o,
    output logic             req0_done_o,
    input  logic             req1_valid_i,
    input  logic [23:0]      req1_addr_i,
    input  logic [LEN_W-1:0] req1_len_i,
    output logic             req1_ready_o,
    output logic             req1_rvalid_o,
    output logic [7:0]       req1_rdata_o,
    output logic             req1_done_o,
    output logic             mem_valid_o,
    output logic [23:0]      mem_addr_o,
    input  logic             mem_ready_i,
    input  logic [7:0]       mem_rdata_i,
    output logic             busy_o,
    output logic             grant_o
);
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, STEP = 2'd2;
    logic [1:0]       state;
    logic [LEN_W-1:0] remaining;
    logic             last;
    logic             sel;
    // On a tie the requester that did not own the last completed burst wins
    always_comb sel = (req0_valid_i && req1_valid_i) ? ~last : req1_valid_i;
    // mem_addr_o doubles as the running burst address
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            remaining     <= '0;
            last          <= 1'b1;
            grant_o       <= 1'b0;
            busy_o        <= 1'b0;
            mem_valid_o   <= 1'b0;
            mem_addr_o    <= '0;
            req0_ready_o  <= 1'b0;
            req0_rvalid_o <= 1'b0;
            req0_rdata_o  <= '0;
            req0_done_o   <= 1'b0;
            req1_ready_o  <= 1'b0;
            req1_rvalid_o <= 1'b0;
            req1_rdata_o  <= '0;
            req1_done_o   <= 1'b0;
        end else begin
            req0_ready_o  <= 1'b0;
            req0_rvalid_o <= 1'b0;
            req0_done_o   <= 1'b0;
            req1_ready_o  <= 1'b0;
            req1_rvalid_o <= 1'b0;
            req1_done_o   <= 1'b0;
            case (state)
                IDLE: if (req0_valid_i || req1_valid_i) begin
                    grant_o      <= sel;
                    req0_ready_o <= ~sel;
                    req1_ready_o <= sel;
                    mem_addr_o   <= sel ? req1_addr_i : req0_addr_i;
                    remaining    <= sel ? req1_len_i : req0_len_i;
                    mem_valid_o  <= 1'b1;
                    busy_o       <= 1'b1;
                    state        <= READ;
                end
                READ: if (mem_ready_i) begin
                    mem_valid_o <= 1'b0;
                    if (grant_o) begin
                        req1_rvalid_o <= 1'b1;
                        req1_rdata_o  <= mem_rdata_i;
                    end else begin
                        req0_rvalid_o <= 1'b1;
                        req0_rdata_o  <= mem_rdata_i;
                    end
                    if (remaining != '0) begin
                        mem_addr_o <= mem_addr_o + 24'd1;
                        remaining  <= remaining - LEN_W'(1);
                        state      <= STEP;
                    end else begin
                        req0_done_o <= ~grant_o;
                        req1_done_o <= grant_o;
                        last        <= grant_o;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                STEP: begin
                    mem_valid_o <= 1'b1;
                    state       <= READ;
                end
                default: begin
                    mem_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_flash_burst_arbiter.sv
// tb_flash_burst_arbiter: randomized and directed bursts checked against a transaction-level model
module tb_flash_burst_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        r0_v, r1_v;
    logic [23:0] r0_a, r1_a;
    logic [7:0]  r0_l, r1_l;
    logic        r0_rdy, r0_rv, r0_dn, r1_rdy, r1_rv, r1_dn;
    logic [7:0]  r0_rd, r1_rd;
    logic        mem_valid, mem_ready, busy, grant;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata;
    int          checks = 0;
    int          errors = 0;
    bit          last = 1'b1;
    logic [7:0]  exp_rd [2];

    flash_burst_arbiter #(.LEN_W(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(r0_v), .req0_addr_i(r0_a), .req0_len_i(r0_l),
        .req0_ready_o(r0_rdy), .req0_rvalid_o(r0_rv), .req0_rdata_o(r0_rd), .req0_done_o(r0_dn),
        .req1_valid_i(r1_v), .req1_addr_i(r1_a), .req1_len_i(r1_l),
        .req1_ready_o(r1_rdy), .req1_rvalid_o(r1_rv), .req1_rdata_o(r1_rd), .req1_done_o(r1_dn),
        .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
        .busy_o(busy), .grant_o(grant)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ready", {r0_rdy, r1_rdy}, 0);
        chk("rst_rvalid", {r0_rv, r1_rv}, 0);
        chk("rst_done", {r0_dn, r1_dn}, 0);
        chk("rst_rdata0", r0_rd, 0);
        chk("rst_rdata1", r1_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
    endtask

    task automatic set_req(input bit n, input logic [23:0] a, input logic [7:0] l);
        if (n) begin r1_v = 1; r1_a = a; r1_l = l; end
        else begin r0_v = 1; r0_a = a; r0_l = l; end
    endtask

    // Serve one arbitrated burst as the memory; dly < 0 picks random read latency,
    // spur injects a mem_ready in each inter-byte gap, stop > 0 abandons after that many bytes.
    task automatic run_burst(input int dly, input bit spur, input int stop);
        bit          g, got;
        logic [23:0] a, ea;
        int          n, d;
        logic [7:0]  b;
        g = (r0_v && r1_v) ? !last : r1_v;
        a = g ? r1_a : r0_a;
        n = int'(g ? r1_l : r0_l) + 1;
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            tick;
            got = r0_rdy | r1_rdy;
        end
        chk("grant_wait", got, 1);
        chk("grant", grant, g);
        chk("ready_owner", g ? r1_rdy : r0_rdy, 1);
        chk("ready_other", g ? r0_rdy : r1_rdy, 0);
        chk("busy", busy, 1);
        if (g) r1_v = 0; else r0_v = 0;
        for (int i = 0; i < n; i++) begin
            ea = a + 24'(i);
            chk("mem_valid", mem_valid, 1);
            chk("mem_addr", mem_addr, ea);
            d = dly < 0 ? int'($urandom_range(0, 3)) : dly;
            repeat (d) tick;
            chk("addr_stable", {mem_valid, mem_addr}, {1'b1, ea});
            b = 8'($urandom);
            mem_ready = 1;
            mem_rdata = b;
            tick;
            mem_ready = 0;
            exp_rd[g] = b;
            chk("rvalid_owner", g ? r1_rv : r0_rv, 1);
            chk("rvalid_other", g ? r0_rv : r1_rv, 0);
            chk("rdata0", r0_rd, exp_rd[0]);
            chk("rdata1", r1_rd, exp_rd[1]);
            chk("done_owner", g ? r1_dn : r0_dn, i == n - 1);
            chk("done_other", g ? r0_dn : r1_dn, 0);
            chk("ready_pulse", {r0_rdy, r1_rdy}, 0);
            chk("gap_valid", mem_valid, 0);
            if (stop > 0 && i + 1 == stop) return;
            if (i == n - 1) begin
                last = g;
                chk("busy_end", busy, 0);
            end else begin
                if (spur) begin
                    mem_ready = 1;
                    mem_rdata = 8'($urandom);
                end
                tick;
                mem_ready = 0;
                chk("step_no_rvalid", {r0_rv, r1_rv}, 0);
            end
        end
    endtask

    initial begin
        logic [23:0] hold;
        rst = 1; r0_v = 0; r1_v = 0; r0_a = 0; r1_a = 0; r0_l = 0; r1_l = 0;
        mem_ready = 0; mem_rdata = 0;
        exp_rd[0] = 0; exp_rd[1] = 0;
        tick;
        tick;
        rst = 0;
        chk_reset;
        // incrementing 4-byte burst with fixed latency
        set_req(0, 24'h001000, 8'd3);
        run_burst(2, 0, 0);
        // simultaneous single-byte requests, then repeated ties
        set_req(0, 24'h000100, 8'd0);
        set_req(1, 24'h000200, 8'd0);
        run_burst(-1, 0, 0);
        run_burst(-1, 0, 0);
        for (int t = 0; t < 4; t++) begin
            set_req(0, 24'h000300, 8'd0);
            set_req(1, 24'h000400, 8'd0);
            run_burst(0, 0, 0);
            r0_v = 0; r1_v = 0;
        end
        // address wrap at the top of the 24-bit space
        set_req(1, 24'hFFFFFE, 8'd2);
        run_burst(-1, 1, 0);
        // maximum length burst
        set_req(0, 24'h7FFF80, 8'hFF);
        run_burst(0, 0, 0);
        // random mixes of requesters, addresses, lengths and latencies
        for (int t = 0; t < 12; t++) begin
            int m;
            m = int'($urandom_range(1, 3));
            if (m[0]) set_req(0, 24'($urandom), 8'($urandom_range(0, 5)));
            if (m[1]) set_req(1, 24'($urandom), 8'($urandom_range(0, 5)));
            run_burst(-1, 1'($urandom), 0);
            r0_v = 0; r1_v = 0;
        end
        // reset mid-burst with a coincident mem_ready
        set_req(0, 24'h00ABCD, 8'd3);
        run_burst(1, 0, 2);
        rst = 1;
        mem_ready = 1;
        mem_rdata = 8'h5A;
        tick;
        rst = 0;
        mem_ready = 0;
        last = 1;
        exp_rd[0] = 0;
        exp_rd[1] = 0;
        chk_reset;
        tick;
        chk("post_rst_idle", {mem_valid, busy, r0_dn, r1_dn}, 0);
        set_req(1, 24'h123456, 8'd1);
        run_burst(-1, 1, 0);
        // spurious completion while idle
        tick;
        hold = mem_addr;
        mem_ready = 1;
        mem_rdata = 8'hC3;
        tick;
        mem_ready = 0;
        tick;
        chk("idle_spur_rvalid", {r0_rv, r1_rv}, 0);
        chk("idle_spur_addr", mem_addr, hold);
        chk("idle_spur_valid", {mem_valid, busy}, 0);
        chk("idle_spur_rdata", {r0_rd, r1_rd}, {exp_rd[0], exp_rd[1]});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
